// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encoding, field widths, limits and 12h display mapping.
package rtc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] h12;
        h12 = h == '0 ? 5'd12 : h > 5'd12 ? h - 5'd12 : h;
        return {h >= 5'd12, h12};
    endfunction
endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk by TICK_DIV into a one-cycle tick while enabled.
module rtc_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int DIV_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [DIV_W-1:0] cnt;
    logic             last;
    assign last = cnt == DIV_W'(TICK_DIV - 1);
    assign tick = enable & last;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: hh:mm:ss timekeeper with prescaler, 12/24h display, time load and one-shot alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              mode_12h,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [SEC_W-1:0]  set_sec,
    output logic              set_err,
    input  logic              alarm_wr,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_en,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_wrap,
    output logic              alarm_hit
);
    state_t            state, state_d;
    logic [SEC_W-1:0]  sec_q, sec_n;
    logic [MIN_W-1:0]  min_q, min_n, alarm_m;
    logic [HOUR_W-1:0] hour_q, hour_n, alarm_h, hour12;
    logic              accept, legal, tick, pm12;
    logic              sec_wrap, min_wrap, hour_wrap, alarm_match;

    assign set_ready = state != LOAD;
    assign accept    = set_valid & set_ready;
    assign legal     = set_hour <= HOUR_MAX && set_min <= MIN_MAX && set_sec <= SEC_MAX;

    rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (state == RUN),
        .clear  (accept),
        .tick   (tick)
    );

    always_comb begin
        state_d = accept ? LOAD : run_en ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        sec_wrap    = sec_q == SEC_MAX;
        min_wrap    = min_q == MIN_MAX;
        hour_wrap   = hour_q == HOUR_MAX;
        sec_n       = sec_wrap ? '0 : sec_q + 1'b1;
        min_n       = !sec_wrap ? min_q : min_wrap ? '0 : min_q + 1'b1;
        hour_n      = !(sec_wrap && min_wrap) ? hour_q : hour_wrap ? '0 : hour_q + 1'b1;
        alarm_match = sec_n == '0 && min_n == alarm_m && hour_n == alarm_h;
    end

    // An accepted load wins over a coincident tick; that tick is simply lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            alarm_h   <= '0;
            alarm_m   <= '0;
            set_err   <= 1'b0;
            sec_tick  <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            set_err   <= accept & ~legal;
            sec_tick  <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
            if (alarm_wr) begin
                alarm_h <= alarm_hour > HOUR_MAX ? HOUR_MAX : alarm_hour;
                alarm_m <= alarm_min > MIN_MAX ? MIN_MAX : alarm_min;
            end
            if (accept) begin
                if (legal) begin
                    sec_q  <= set_sec;
                    min_q  <= set_min;
                    hour_q <= set_hour;
                end
            end else if (tick) begin
                sec_q     <= sec_n;
                min_q     <= min_n;
                hour_q    <= hour_n;
                sec_tick  <= 1'b1;
                day_wrap  <= sec_wrap & min_wrap & hour_wrap;
                alarm_hit <= alarm_en & alarm_match;
            end
        end
    end

    assign {pm12, hour12} = to_12h(hour_q);
    assign sec  = sec_q;
    assign min  = min_q;
    assign hour = mode_12h ? hour12 : hour_q;
    assign pm   = mode_12h & pm12;
endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised hh:mm:ss timekeeper, successor to the plain sec/min counter. Adds an on-chip prescaler that derives the one-second tick from clk, an hours counter, a run-time 12/24-hour display mode, a valid/ready time-load interface and a one-shot alarm. Sits between the system clock domain and display/alarm logic; all outputs are synchronous to clk.

Parameters:
TICK_DIV, 50_000_000, clk cycles per second tick; legal range >= 1; benches use 4.
DIV_W, $clog2(TICK_DIV) with a minimum of 1, width of the prescaler counter (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
run_en  in  1  1 = time advances; 0 = frozen (prescaler held).
mode_12h  in  1  display mode: 1 = 12-hour, 0 = 24-hour; affects outputs only.
set_valid  in  1  time-load request.
set_ready  out  1  load accepted when set_valid & set_ready.
set_hour  in  5  load hour, 0..23.
set_min  in  6  load minute, 0..59.
set_sec  in  6  load second, 0..59.
set_err  out  1  one-cycle pulse: accepted load was out of range.
alarm_wr  in  1  write alarm_hour/alarm_min into alarm registers.
alarm_hour  in  5  0..23.
alarm_min  in  6  0..59.
alarm_en  in  1  alarm arming enable.
sec  out  6  seconds 0..59.
min  out  6  minutes 0..59.
hour  out  5  24h: 0..23; 12h: 1..12.
pm  out  1  12h mode: 1 when internal hour >= 12; 0 in 24h mode.
sec_tick  out  1  one-cycle pulse on every second advance.
day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
alarm_hit  out  1  one-cycle pulse on alarm match.

Behaviour:
- Reset (rst low, asynchronous): time 00:00:00, prescaler 0, alarm regs 0, FSM IDLE; set_ready=1; set_err, sec_tick, day_wrap, alarm_hit = 0; hour output reads 12 if mode_12h=1, else 0.
- FSM states:
  - IDLE: run_en=0. Goes to RUN when run_en=1.
  - RUN: goes to IDLE when run_en=0.
  - LOAD: entered from IDLE or RUN on an accepted set. Lasts exactly one cycle, then returns to RUN if run_en=1, else IDLE.
  - set_ready=0 only while in LOAD, so back-to-back loads are spaced by at least 2 cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - tick is asserted in the cycle the count equals TICK_DIV-1. With TICK_DIV=1, tick is asserted every RUN cycle.
  - Held in IDLE; cleared to 0 on set accept.
- Advance on tick (registered; sec_tick is high in the same cycle the new value appears):
  - sec 59 -> 0 with min+1; min 59 -> 0 with hour+1; hour 23 -> 0.
  - day_wrap is asserted together with sec_tick at 23:59:59 -> 00:00:00.
- Load: on the accept cycle, operands are range-checked.
  - Legal: time takes the new values on the next edge.
  - Illegal (hour > 23, min > 59 or sec > 59): time is unchanged and set_err pulses on the next cycle.
  - Accept has priority over a coincident tick; that tick is dropped and no sec_tick is produced.
- Display mapping (combinational from the internal 0..23 hour):
  - 12h mode: 0 -> 12 with pm=0; 1..11 -> same with pm=0; 12 -> 12 with pm=1; 13..23 -> h-12 with pm=1.
  - mode_12h may toggle at any time; the outputs follow in the same cycle and the time state is unaffected.
- Alarm:
  - alarm_wr loads the alarm registers on the next edge. Values are clamped: hour > 23 -> 23, min > 59 -> 59.
  - alarm_hit pulses for one cycle, coincident with sec_tick, when a tick makes the time equal alarm_hour:alarm_min:00 and alarm_en=1.
  - A load that lands exactly on the alarm time does not fire alarm_hit.
  - alarm_wr in the same cycle as the matching tick compares against the old alarm value.
- Reset asserted mid-operation: immediate return to reset state, including pending pulses.
- Arithmetic: all compares are unsigned; no counter ever holds a value outside its stated range.

Decomposition:
- Package rtc_pkg:
  - state enum {IDLE, RUN, LOAD}.
  - SEC_W=6, MIN_W=6, HOUR_W=5.
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Function to_12h(hour) returning {pm, hour12}.
- One sub-module, rtc_prescaler: parametrised by TICK_DIV; inputs enable and clear; output tick. It is reused by the stopwatch block.

Test Plan:
- TICK_DIV=4, reset release, run_en=1 -> sec_tick every 4th cycle; sec reads 1 after the first tick; 60 ticks -> min=1, sec=0.
- Load 23:59:58, run -> after 2 ticks time 00:00:00, day_wrap and sec_tick high in the same cycle, exactly once.
- set_valid with set_hour=24 -> set_err pulse next cycle, time unchanged; set_ready low for exactly 1 cycle, then high.
- Load 13:05:00 with mode_12h=1 -> hour=1, pm=1; toggle mode_12h=0 -> hour=13, pm=0 same cycle; load 00:00:00 in 12h -> hour=12, pm=0.
- alarm_wr 07:30, alarm_en=1, load 07:29:59, run -> alarm_hit on the next tick only; repeat with alarm_en=0 -> no pulse; load 07:30:00 directly -> no pulse.
- run_en=0 mid-count (prescaler=2) for 10 cycles, then run_en=1 -> first tick 1 cycle after resume; rst pulsed low mid-count -> outputs 00:00:00 asynchronously, before the next clk edge.
